// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the unified single-ported memory shared by IF and MEM.
// MEM (data) has fixed priority; registered request/ready handshake toward memory.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [1:0]    mem_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          align_err,
   output logic          timeout_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DATA  = 2'd1;
   localparam logic [1:0] S_FETCH = 2'd2;

   localparam int            CW        = $clog2(TIMEOUT + 2);
   localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);

   logic [1:0]    state;
   logic [CW-1:0] wait_cnt;
   logic          d_pend;
   logic          if_pend;
   logic          d_misalign;
   logic          busy;
   logic          done;
   logic          tmo;
   logic          grant_d;
   logic          grant_f;
   logic          reject;

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = d_req & ~d_ack;

   // A request is still "held" during its own ack cycle; masking with the ack
   // keeps the arbiter from re-granting an already completed access.
   always_comb begin
      d_pend     = stall_mem;
      if_pend    = stall_if;
      d_misalign = ((d_size == 2'b01) && d_addr[0]) ||
                   ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));
      busy       = (state == S_DATA) || (state == S_FETCH);
      done       = busy && mem_ready;
      tmo        = busy && !mem_ready && (TIMEOUT != 0) && (wait_cnt == TMO_LIMIT);
      grant_d    = d_pend && !d_misalign &&
                   ((state == S_IDLE) || ((state == S_FETCH) && done));
      grant_f    = if_pend &&
                   (((state == S_IDLE) && !d_pend) || ((state == S_DATA) && done));
      reject     = (state == S_IDLE) && d_pend && d_misalign;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_size    <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         if_ack      <= 1'b0;
         d_ack       <= 1'b0;
         if_rdata    <= '0;
         d_rdata     <= '0;
         align_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         align_err <= 1'b0;

         if (grant_d) begin
            state     <= S_DATA;
            wait_cnt  <= '0;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_size  <= d_size;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else if (grant_f) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_size <= 2'b10;
            mem_addr <= if_addr;
         end else if (done || tmo) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
         end else if (busy && (TIMEOUT != 0)) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else if (!busy && (state != S_IDLE)) begin
            state <= S_IDLE;
         end

         // Completion and abort share the ack path; abort forces zero data.
         if (done || tmo) begin
            if (state == S_DATA) begin
               d_ack <= 1'b1;
               if (tmo)
                  d_rdata <= '0;
               else if (!mem_we)
                  d_rdata <= mem_rdata;
            end else begin
               if_ack   <= 1'b1;
               if_rdata <= tmo ? '0 : mem_rdata;
            end
         end

         if (tmo)
            timeout_err <= 1'b1;

         if (reject) begin
            d_ack     <= 1'b1;
            align_err <= 1'b1;
            d_rdata   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_if;
   logic        stall_mem;
   logic        align_err;
   logic        timeout_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .align_err(align_err), .timeout_err(timeout_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: who owns the memory (0 none, 1 data, 2 fetch) and the
   // values every registered output should show after the coming edge.
   int          owner;
   int unsigned waited;
   logic        m_req, m_we, m_if_ack, m_d_ack, m_align, m_tmo;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

   task automatic model_reset();
      owner = 0; waited = 0;
      m_req = 0; m_we = 0; m_if_ack = 0; m_d_ack = 0; m_align = 0; m_tmo = 0;
      m_size = '0; m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
   endtask

   task automatic model_step();
      bit d_pend, i_pend, d_bad, fin, expire;
      int prev;
      d_pend = d_req && !m_d_ack;
      i_pend = if_req && !m_if_ack;
      d_bad  = (d_size == 2'd1 && d_addr[0]) || (d_size == 2'd2 && d_addr[1:0] != 2'd0);
      prev   = owner;
      fin    = (owner != 0) && mem_ready;
      expire = (TO > 0) && (owner != 0) && !mem_ready && (waited == TO);
      m_if_ack = 0; m_d_ack = 0; m_align = 0;
      if (fin || expire) begin
         if (prev == 1) begin
            m_d_ack = 1;
            if (expire) m_d_rdata = '0;
            else if (!m_we) m_d_rdata = mem_rdata;
         end else begin
            m_if_ack   = 1;
            m_if_rdata = expire ? 32'd0 : mem_rdata;
         end
         if (expire) m_tmo = 1;
         owner = 0;
         m_req = 0;
      end else if (owner != 0) begin
         waited++;
      end
      if (prev == 0 || fin) begin
         if (prev != 1 && d_pend && !d_bad) begin
            owner = 1; waited = 0; m_req = 1;
            m_we = d_we; m_size = d_size; m_addr = d_addr; m_wdata = d_wdata;
         end else if (prev == 0 && d_pend) begin
            m_d_ack = 1; m_align = 1; m_d_rdata = '0;
         end else if (prev != 2 && i_pend) begin
            owner = 2; waited = 0; m_req = 1;
            m_we = 0; m_size = 2'b10; m_addr = if_addr;
         end
      end
   endtask

   task automatic compare_all();
      check("mem_req", mem_req, m_req);
      check("mem_we", mem_we, m_we);
      check("mem_size", mem_size, m_size);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("if_ack", if_ack, m_if_ack);
      check("if_rdata", if_rdata, m_if_rdata);
      check("d_ack", d_ack, m_d_ack);
      check("d_rdata", d_rdata, m_d_rdata);
      check("align_err", align_err, m_align);
      check("timeout_err", timeout_err, m_tmo);
      check("stall_if", stall_if, if_req & ~m_if_ack);
      check("stall_mem", stall_mem, d_req & ~m_d_ack);
   endtask

   // Called at a negedge with this cycle's inputs applied.
   task automatic tick();
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int n;
      rst_n = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_size = '0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_ack", if_ack, 0);
      check("rst_timeout_err", timeout_err, 0);
      compare_all();
      rst_n = 1;

      // fetch only, memory ready on the third cycle
      if_req = 1; if_addr = 32'h100; mem_rdata = 32'hDEAD_BEEF;
      tick();
      check("f_addr", mem_addr, 32'h100);
      check("f_we", mem_we, 0);
      check("f_req", mem_req, 1);
      check("f_stall", stall_if, 1);
      tick();
      mem_ready = 1; mem_rdata = 32'hE3A0_1005;
      tick();
      check("f_ack", if_ack, 1);
      check("f_rdata", if_rdata, 32'hE3A0_1005);
      check("f_stall_ack", stall_if, 0);
      check("f_req_low", mem_req, 0);
      if_req = 0; mem_ready = 0;
      tick();
      check("f_ack_once", if_ack, 0);

      // simultaneous requests: data first, fetch back-to-back
      if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_size = 2'b10;
      d_addr = 32'h200; mem_ready = 1; mem_rdata = 32'h1234_5678;
      tick();
      check("s_data_first", mem_addr, 32'h200);
      tick();
      check("s_d_ack", d_ack, 1);
      check("s_d_rdata", d_rdata, 32'h1234_5678);
      check("s_b2b_addr", mem_addr, 32'h300);
      check("s_b2b_req", mem_req, 1);
      d_req = 0;
      tick();
      check("s_if_ack", if_ack, 1);
      check("s_if_rdata", if_rdata, 32'h1234_5678);
      if_req = 0;
      tick();

      // byte store: d_rdata keeps the previous load value
      d_req = 1; d_we = 1; d_size = 2'b00; d_addr = 32'h203; d_wdata = 32'hAB;
      mem_rdata = 32'hFFFF_0000;
      tick();
      check("st_we", mem_we, 1);
      check("st_size", mem_size, 0);
      check("st_wdata", mem_wdata, 32'hAB);
      tick();
      check("st_ack", d_ack, 1);
      check("st_rdata_hold", d_rdata, 32'h1234_5678);
      d_req = 0; d_we = 0;
      tick();

      // misaligned word load
      d_req = 1; d_size = 2'b10; d_addr = 32'h202;
      tick();
      check("mis_ack", d_ack, 1);
      check("mis_align", align_err, 1);
      check("mis_rdata", d_rdata, 0);
      check("mis_no_req", mem_req, 0);
      d_req = 0;
      tick();
      check("mis_align_pulse", align_err, 0);

      // reset in the middle of a data access
      d_req = 1; d_size = 2'b10; d_addr = 32'h400; mem_ready = 0;
      tick();
      check("rm_req", mem_req, 1);
      rst_n = 0;
      #1;
      check("rm_req_drop", mem_req, 0);
      check("rm_addr_drop", mem_addr, 0);
      check("rm_no_ack", d_ack, 0);
      model_reset();
      d_req = 0;
      @(negedge clk);
      compare_all();
      rst_n = 1;
      if_req = 1; if_addr = 32'h500; mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
      tick();
      tick();
      check("rm_fetch_ack", if_ack, 1);
      check("rm_fetch_data", if_rdata, 32'hCAFE_F00D);
      check("rm_no_d_ack", d_ack, 0);
      if_req = 0;
      tick();

      // timeout on a fetch that never sees mem_ready
      if_req = 1; if_addr = 32'h600; mem_ready = 0; mem_rdata = 32'h7777_7777;
      tick();
      n = -1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (if_ack) begin
            n = k;
            break;
         end
      end
      check("tmo_wait", n, TO);
      check("tmo_rdata", if_rdata, 0);
      check("tmo_err", timeout_err, 1);
      check("tmo_req", mem_req, 0);
      if_req = 0;
      tick();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if (!if_req || m_if_ack) begin
            if_req  = ($urandom % 3) == 0;
            if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req || m_d_ack) begin
            d_req   = ($urandom % 3) == 0;
            d_we    = 1'($urandom % 2);
            d_size  = 2'($urandom % 3);
            d_addr  = $urandom;
            if ($urandom % 2) d_addr[1:0] = 2'b00;
            d_wdata = $urandom;
         end
         mem_ready = ($urandom % 3) == 0;
         mem_rdata = $urandom;
         tick();
      end
      check("tmo_sticky", timeout_err, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter and sequencer for the single-ported unified memory that is shared by the IF stage (instruction fetch) and the MEM stage (load/store). It grants one requester at a time, with the MEM stage having fixed priority because it holds the older instruction. It drives a registered request/ready handshake to the memory. It also produces the stall_if / stall_mem signals that the hazard detection logic uses to hold IF/ID and the PC.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, maximum wait cycles for mem_ready before abort; 0 disables the timeout

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched instruction; valid in the if_ack cycle
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  load/store request; held high until d_ack
d_we  in  1  1 = store, 0 = load
d_size  in  2  access size: 00 = byte, 01 = half, 10 = word
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data; valid in the d_ack cycle
d_ack  out  1  one-cycle data completion pulse
mem_req  out  1  registered memory request
mem_we  out  1  registered write enable
mem_size  out  2  registered size
mem_addr  out  AW  registered address
mem_wdata  out  DW  registered write data
mem_rdata  in  DW  memory read data; valid when mem_ready=1
mem_ready  in  1  memory completion; sampled only while mem_req=1
stall_if  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  d_req & ~d_ack (combinational)
align_err  out  1  one-cycle pulse when a misaligned data access is rejected
timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, if_ack, d_ack, align_err and timeout_err are 0; mem_size, mem_addr, mem_wdata, if_rdata and d_rdata are 0; wait counter is 0. Any in-flight access is dropped and no ack is issued for it.
- States:
  - IDLE: no access in progress.
  - DATA: data access in progress.
  - FETCH: fetch access in progress.
- IDLE arbitration:
  - If d_req=1 and the access is aligned: latch the d_* inputs into the mem_* registers, set mem_req=1, go to DATA.
  - Else if d_req=1 and misaligned (half with addr[0]=1, or word with addr[1:0]!=0): no memory access; next cycle d_ack=1, align_err=1, d_rdata=0; stay in IDLE.
  - Else if if_req=1: latch if_addr into mem_addr, set mem_we=0, mem_size=10, mem_req=1, go to FETCH.
  - If d_req and if_req are both high, data always wins.
- While in DATA or FETCH, the mem_* registers stay stable until mem_ready=1 is sampled.
- Completion (mem_ready=1 on a clock edge):
  - Next cycle the matching ack pulses for 1 cycle. The matching rdata register loads mem_rdata for fetches and loads; for stores, d_rdata holds its previous value.
  - mem_req falls in the ack cycle unless a back-to-back grant follows.
  - Back-to-back grant: on DATA completion with if_req=1, the fetch is latched on the same edge (go to FETCH, no idle cycle). On FETCH completion with d_req=1 and aligned, the data access is latched on the same edge (go to DATA). Otherwise go to IDLE.
- Latency: with mem_ready tied high, a request issued from IDLE is acked 2 cycles after req is sampled.
- Timeout (TIMEOUT>0):
  - The wait counter clears on each grant and increments each DATA/FETCH cycle with mem_ready=0.
  - When it reaches TIMEOUT: mem_req=0, the matching ack pulses with rdata=0, timeout_err is set, and the state goes to IDLE.
  - If mem_ready=1 arrives in the same cycle the counter reaches TIMEOUT, the normal completion is taken and no error is flagged.
- The arbiter ignores if_req/d_req changes during an access. Requesters must hold them; a deasserted request is not aborted.
- stall_if and stall_mem are purely combinational; neither is ever asserted in the cycle of its own ack.

Test Plan:
- Fetch only: if_addr=0x100, mem_ready high on the 3rd cycle with mem_rdata=0xE3A01005 -> mem_addr=0x100, mem_we=0; if_ack pulses once with if_rdata=0xE3A01005; stall_if high until the ack cycle.
- Simultaneous if_req and d_req (load at 0x200) from IDLE, mem_ready always 1 -> DATA is granted first; d_ack at cycle 2; FETCH is granted on the same edge with no idle gap; if_ack at cycle 3.
- Store: d_we=1, d_size=00, d_addr=0x203, d_wdata=0xAB -> mem_we=1, mem_size=00, mem_wdata=0xAB; d_ack pulses; d_rdata unchanged from its prior value.
- Misaligned word load at 0x202 -> mem_req stays 0; d_ack and align_err pulse together one cycle later; d_rdata=0.
- Timeout: TIMEOUT=4, fetch issued with mem_ready held 0 -> after 4 wait cycles mem_req=0, if_ack=1 with if_rdata=0, timeout_err=1, and timeout_err stays 1 across subsequent requests.
- rst_n pulsed low mid-DATA -> all outputs drop to 0 asynchronously with no ack; after release, a new fetch completes normally.
